// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM states and
// instruction word geometry.
package inst_fetch_queue_pkg;

  localparam int unsigned InstW     = 32;
  localparam int unsigned InstBytes = 4;

  typedef enum logic [0:0] {
    StFetch,
    StHalted
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, inst} with flush. The head entry is read
// straight from registered storage; pointers wrap modulo DEPTH.
module inst_fetch_queue_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [XLEN-1:0]  push_pc,
  input  logic [InstW-1:0] push_inst,
  input  logic             pop,
  output logic [XLEN-1:0]  head_pc,
  output logic [InstW-1:0] head_inst,
  output logic [CntW-1:0]  count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [XLEN-1:0]  pc_q   [DEPTH];
  logic [InstW-1:0] inst_q [DEPTH];
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count_q != '0);
  // A push at full is only legal when the head leaves in the same cycle.
  assign do_push = push && ((count_q != CntW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) begin
      pc_q[wr_ptr_q]   <= push_pc;
      inst_q[wr_ptr_q] <= push_inst;
    end
  end

  assign head_pc   = pc_q[rd_ptr_q];
  assign head_inst = inst_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: issues in-order word fetches under a queue credit
// limit, tags returned words with their PC, and flushes on redirect.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req_valid,
  output logic [XLEN-1:0]  mem_req_addr,
  input  logic             mem_req_ready,
  input  logic             mem_resp_valid,
  input  logic [InstW-1:0] mem_resp_data,
  output logic             inst_valid,
  output logic [InstW-1:0] inst,
  output logic [XLEN-1:0]  inst_pc,
  input  logic             inst_ready,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             halt
);

  localparam int unsigned     CntW   = $clog2(DEPTH + 1);
  localparam int unsigned     SumW   = CntW + 1;
  localparam logic [XLEN-1:0] PcStep = XLEN'(InstBytes);

  fetch_state_e     state_q;
  logic [XLEN-1:0]  fetch_pc_q, resp_pc_q, redirect_aligned;
  logic [CntW-1:0]  outstanding_q, outstanding_d, drop_cnt_q, count;
  logic [XLEN-1:0]  head_pc;
  logic [InstW-1:0] head_inst;
  logic             in_fetch, redirect, credit_ok, req_fire, resp_drop, push, pop;

  assign in_fetch         = (state_q == StFetch);
  assign redirect         = in_fetch && redirect_valid && !reset;
  assign redirect_aligned = redirect_pc & ~(PcStep - 1'b1);

  // Queue slots are reserved at request time, so responses can never overflow.
  assign credit_ok     = (SumW'(count) + SumW'(outstanding_q)) < SumW'(DEPTH);
  assign mem_req_valid = !reset && in_fetch && !redirect_valid && !halt && credit_ok;
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign resp_drop = mem_resp_valid && (drop_cnt_q != '0);
  assign push      = mem_resp_valid && !resp_drop && !redirect;

  assign inst_valid = !reset && (count != '0);
  assign pop        = inst_valid && inst_ready && !redirect;
  assign inst       = reset ? '0 : head_inst;
  assign inst_pc    = reset ? '0 : head_pc;

  assign outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(mem_resp_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StFetch;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      if (redirect) begin
        fetch_pc_q <= redirect_aligned;
        resp_pc_q  <= redirect_aligned;
        // Everything still in flight belongs to the abandoned path.
        drop_cnt_q <= outstanding_d;
      end else begin
        if (req_fire)  fetch_pc_q <= fetch_pc_q + PcStep;
        if (push)      resp_pc_q  <= resp_pc_q + PcStep;
        if (resp_drop) drop_cnt_q <= drop_cnt_q - 1'b1;
      end
      unique case (state_q)
        StFetch:  if (halt) state_q <= StHalted;
        StHalted: state_q <= StHalted;
      endcase
    end
  end

  inst_fetch_queue_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_pc   (resp_pc_q),
    .push_inst (mem_resp_data),
    .pop       (pop),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .count     (count)
  );

  resp_no_overflow_a: assert property (@(posedge clk) disable iff (reset)
    !(mem_resp_valid && (count == CntW'(DEPTH))));

  credit_bound_a: assert property (@(posedge clk) disable iff (reset)
    (SumW'(count) + SumW'(outstanding_q)) <= SumW'(DEPTH));

  drop_bound_a: assert property (@(posedge clk) disable iff (reset)
    drop_cnt_q <= outstanding_q);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a vector table for streaming/backpressure
// plus hand-written redirect, halt and address-wrap sequences.
module tb_inst_fetch_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            mem_req_valid;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_ready;
  logic            mem_resp_valid;
  logic [31:0]     mem_resp_data;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt;

  inst_fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 1;

  // In-order memory model: a request accepted in cycle c answers in cycle c+lat.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[20];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Called just after an edge once inputs for the cycle are driven.
  task automatic check_cycle(input string tag, input logic rv, input logic [31:0] addr,
                             input logic iv, input logic [31:0] pc);
    #1;
    chk({tag, ".req_valid"}, 32'(mem_req_valid), 32'(rv));
    if (rv) chk({tag, ".req_addr"}, mem_req_addr, addr);
    chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(iv));
    if (iv) begin
      chk({tag, ".inst_pc"}, inst_pc, pc);
      chk({tag, ".inst"}, inst, word_at(pc));
    end
    if (reset) begin
      chk({tag, ".inst_rst"}, inst, 32'h0);
      chk({tag, ".inst_pc_rst"}, inst_pc, 32'h0);
    end
  endtask

  task automatic step();
    logic        acc;
    logic [31:0] a;
    mreq_t       e;
    if (reset) mq.delete();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = word_at(mq[0].addr);
    end
    #1;
    acc = mem_req_valid && mem_req_ready;
    a   = mem_req_addr;
    @(posedge clk);
    if (mem_resp_valid) void'(mq.pop_front());
    if (acc) begin
      e.addr = a;
      e.due  = cyc + lat;
      mq.push_back(e);
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    inst_ready     = 1'b1;
    mem_req_ready  = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    inst_ready     = 1'b1;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    @(posedge clk);
    #1;

    // Streaming after reset, mid-run reset, then backpressure fill and resume.
    //          rst  rdy  rv   addr    iv   pc
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 32'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 32'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'd16, 1'b1, 32'd8};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'd20, 1'b1, 32'd12};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'd4,  1'b0, 32'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'd8,  1'b1, 32'd0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 32'd12, 1'b1, 32'd0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 32'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 32'd0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 32'd0,  1'b1, 32'd0};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 32'd16, 1'b1, 32'd4};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 32'd20, 1'b1, 32'd8};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 32'd24, 1'b1, 32'd12};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 32'd28, 1'b1, 32'd16};

    lat = 1;
    for (int i = 0; i < 20; i++) begin
      reset      = vecs[i].rst;
      inst_ready = vecs[i].rdy;
      check_cycle($sformatf("vec%0d", i), vecs[i].exp_rv, vecs[i].exp_addr,
                  vecs[i].exp_iv, vecs[i].exp_pc);
      step();
    end

    // Redirect to 0x103 with two requests in flight, latency 3.
    lat = 3;
    do_reset();
    check_cycle("rd.c0", 1'b1, 32'h0, 1'b0, 32'h0);     step();
    check_cycle("rd.c1", 1'b1, 32'h4, 1'b0, 32'h0);     step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    check_cycle("rd.c2", 1'b0, 32'h0, 1'b0, 32'h0);     step();
    redirect_valid = 1'b0;
    check_cycle("rd.c3", 1'b1, 32'h100, 1'b0, 32'h0);   step();
    check_cycle("rd.c4", 1'b1, 32'h104, 1'b0, 32'h0);   step();
    check_cycle("rd.c5", 1'b1, 32'h108, 1'b0, 32'h0);   step();
    check_cycle("rd.c6", 1'b1, 32'h10c, 1'b0, 32'h0);   step();
    check_cycle("rd.c7", 1'b0, 32'h0, 1'b1, 32'h100);   step();
    check_cycle("rd.c8", 1'b1, 32'h110, 1'b1, 32'h104); step();

    // Fill to DEPTH, drain, then redirect while a push and pop coincide.
    lat = 2;
    do_reset();
    inst_ready = 1'b0;
    check_cycle("rp.c0", 1'b1, 32'h0, 1'b0, 32'h0);     step();
    check_cycle("rp.c1", 1'b1, 32'h4, 1'b0, 32'h0);     step();
    check_cycle("rp.c2", 1'b1, 32'h8, 1'b0, 32'h0);     step();
    check_cycle("rp.c3", 1'b1, 32'hc, 1'b1, 32'h0);     step();
    check_cycle("rp.c4", 1'b0, 32'h0, 1'b1, 32'h0);     step();
    check_cycle("rp.c5", 1'b0, 32'h0, 1'b1, 32'h0);     step();
    inst_ready = 1'b1;
    check_cycle("rp.c6", 1'b0, 32'h0, 1'b1, 32'h0);     step();
    check_cycle("rp.c7", 1'b1, 32'h10, 1'b1, 32'h4);    step();
    check_cycle("rp.c8", 1'b1, 32'h14, 1'b1, 32'h8);    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    check_cycle("rp.c9", 1'b0, 32'h0, 1'b1, 32'hc);     step();
    redirect_valid = 1'b0;
    check_cycle("rp.c10", 1'b1, 32'h200, 1'b0, 32'h0);  step();
    check_cycle("rp.c11", 1'b1, 32'h204, 1'b0, 32'h0);  step();
    check_cycle("rp.c12", 1'b1, 32'h208, 1'b0, 32'h0);  step();
    check_cycle("rp.c13", 1'b1, 32'h20c, 1'b1, 32'h200); step();

    // Halt with three requests outstanding; a later redirect must be ignored.
    lat = 3;
    do_reset();
    check_cycle("ht.c0", 1'b1, 32'h0, 1'b0, 32'h0);     step();
    check_cycle("ht.c1", 1'b1, 32'h4, 1'b0, 32'h0);     step();
    check_cycle("ht.c2", 1'b1, 32'h8, 1'b0, 32'h0);     step();
    halt = 1'b1;
    check_cycle("ht.c3", 1'b0, 32'h0, 1'b0, 32'h0);     step();
    halt = 1'b0;
    check_cycle("ht.c4", 1'b0, 32'h0, 1'b1, 32'h0);     step();
    check_cycle("ht.c5", 1'b0, 32'h0, 1'b1, 32'h4);     step();
    check_cycle("ht.c6", 1'b0, 32'h0, 1'b1, 32'h8);     step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    check_cycle("ht.c7", 1'b0, 32'h0, 1'b0, 32'h0);     step();
    redirect_valid = 1'b0;
    for (int i = 8; i < 12; i++) begin
      check_cycle($sformatf("ht.c%0d", i), 1'b0, 32'h0, 1'b0, 32'h0);
      step();
    end

    // Address wrap at the top of the space, with one cycle of memory stall.
    lat = 1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hffff_fffc;
    check_cycle("wr.c0", 1'b0, 32'h0, 1'b0, 32'h0);            step();
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b0;
    check_cycle("wr.c1", 1'b1, 32'hffff_fffc, 1'b0, 32'h0);    step();
    mem_req_ready  = 1'b1;
    check_cycle("wr.c2", 1'b1, 32'hffff_fffc, 1'b0, 32'h0);    step();
    check_cycle("wr.c3", 1'b1, 32'h0, 1'b0, 32'h0);            step();
    check_cycle("wr.c4", 1'b1, 32'h4, 1'b1, 32'hffff_fffc);    step();
    check_cycle("wr.c5", 1'b1, 32'h8, 1'b1, 32'h0);            step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
